// File: rtl/div_request_sequencer.sv
// -----------------------------------------------------------------------------
// div_request_sequencer
//
// Front/back-end stage for the 8-bit non-restoring divider. Division requests
// are taken on a valid/ready port and queued in a small FIFO. One operation at
// a time is handed to the divider through its start/ready handshake, and the
// result is returned with the request tag on a valid/ready response port.
// Divide-by-zero is answered locally and never reaches the divider. A divider
// that never raises div_ready is abandoned after TIMEOUT cycles.
//
// Parameters
//   DEPTH    request FIFO depth (power of 2, >= 2)
//   TAG_W    width of the opaque request tag
//   TIMEOUT  cycles allowed in WAIT_DONE before the operation is aborted
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   req_valid/req_ready        request handshake (req_ready = FIFO not full)
//   req_dividend/req_divisor   unsigned 8-bit operands
//   req_tag                    tag echoed on the response
//   rsp_valid/rsp_ready        response handshake, rsp_valid held until taken
//   rsp_quotient/rsp_remainder result (FF/dividend on dbz, 0/0 on timeout)
//   rsp_tag                    tag of the answered request
//   rsp_dbz, rsp_timeout       status flags
//   div_start                  one-cycle start pulse to the divider
//   div_dividend/div_divisor   operands, stable from ISSUE through WAIT_DONE
//   div_quotient/div_remainder divider result, valid while div_ready is high
//   div_ready                  divider done level
//   busy                       FSM not in IDLE
//   fifo_count                 current FIFO occupancy
// -----------------------------------------------------------------------------
module div_request_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [7:0]             req_dividend,
  input  logic [7:0]             req_divisor,
  input  logic [TAG_W-1:0]       req_tag,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [7:0]             rsp_quotient,
  output logic [7:0]             rsp_remainder,
  output logic [TAG_W-1:0]       rsp_tag,
  output logic                   rsp_dbz,
  output logic                   rsp_timeout,
  output logic                   div_start,
  output logic [7:0]             div_dividend,
  output logic [7:0]             div_divisor,
  input  logic [7:0]             div_quotient,
  input  logic [7:0]             div_remainder,
  input  logic                   div_ready,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_CLR,
    S_WAIT_DONE,
    S_RESP
  } state_t;

  // FIFO storage, one array per field
  logic [7:0]       fifo_dividend_q [DEPTH];
  logic [7:0]       fifo_divisor_q  [DEPTH];
  logic [TAG_W-1:0] fifo_tag_q      [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  state_t           state_q, state_d;
  logic [7:0]       op_dividend_q, op_dividend_d;
  logic [7:0]       op_divisor_q, op_divisor_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [TO_W-1:0]  to_cnt_inc;

  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_quotient_q, rsp_quotient_d;
  logic [7:0]       rsp_remainder_q, rsp_remainder_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             rsp_dbz_q, rsp_dbz_d;
  logic             rsp_timeout_q, rsp_timeout_d;

  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic [7:0]       head_dividend;
  logic [7:0]       head_divisor;
  logic [TAG_W-1:0] head_tag;

  assign req_ready     = (count_q != CNT_W'(DEPTH));
  assign fifo_empty    = (count_q == '0);
  assign push          = req_valid && req_ready;
  assign head_dividend = fifo_dividend_q[rd_ptr_q];
  assign head_divisor  = fifo_divisor_q[rd_ptr_q];
  assign head_tag      = fifo_tag_q[rd_ptr_q];
  assign to_cnt_inc    = to_cnt_q + TO_W'(1);

  // FIFO payload write; the storage itself needs no reset because only
  // entries below the occupancy count are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dividend_q[wr_ptr_q] <= req_dividend;
      fifo_divisor_q[wr_ptr_q]  <= req_divisor;
      fifo_tag_q[wr_ptr_q]      <= req_tag;
    end
  end

  // Next-state logic for the sequencer FSM, the operand/response registers
  // and the FIFO pointers. Every _d starts as a copy of its _q so that only
  // the fields a state actually changes need to be written.
  always_comb begin
    state_d         = state_q;
    op_dividend_d   = op_dividend_q;
    op_divisor_d    = op_divisor_q;
    to_cnt_d        = to_cnt_q;
    rsp_valid_d     = rsp_valid_q;
    rsp_quotient_d  = rsp_quotient_q;
    rsp_remainder_d = rsp_remainder_q;
    rsp_tag_d       = rsp_tag_q;
    rsp_dbz_d       = rsp_dbz_q;
    rsp_timeout_d   = rsp_timeout_q;
    pop             = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty && !rsp_valid_q) begin
          pop           = 1'b1;
          op_dividend_d = head_dividend;
          op_divisor_d  = head_divisor;
          rsp_tag_d     = head_tag;
          rsp_dbz_d     = 1'b0;
          rsp_timeout_d = 1'b0;
          // A zero divisor is answered here without touching the divider.
          if (head_divisor == 8'd0) begin
            rsp_quotient_d  = 8'hFF;
            rsp_remainder_d = head_dividend;
            rsp_dbz_d       = 1'b1;
            rsp_valid_d     = 1'b1;
            state_d         = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT_CLR;
      end

      // The divider still shows its previous done level here, so div_ready
      // is deliberately not looked at in this state.
      S_WAIT_CLR: begin
        to_cnt_d = '0;
        state_d  = S_WAIT_DONE;
      end

      S_WAIT_DONE: begin
        if (div_ready) begin
          rsp_quotient_d  = div_quotient;
          rsp_remainder_d = div_remainder;
          rsp_dbz_d       = 1'b0;
          rsp_timeout_d   = 1'b0;
          rsp_valid_d     = 1'b1;
          state_d         = S_RESP;
        end else begin
          to_cnt_d = to_cnt_inc;
          // Leaving on the cycle the count hits TIMEOUT puts rsp_valid up
          // exactly TIMEOUT cycles after WAIT_DONE was entered.
          if (to_cnt_inc == TO_W'(TIMEOUT)) begin
            rsp_quotient_d  = 8'd0;
            rsp_remainder_d = 8'd0;
            rsp_timeout_d   = 1'b1;
            rsp_valid_d     = 1'b1;
            state_d         = S_RESP;
          end
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State register. Reset wins over everything, so an operation caught in
  // flight is dropped and whatever the divider returns later is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      op_dividend_q   <= '0;
      op_divisor_q    <= '0;
      to_cnt_q        <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_quotient_q  <= '0;
      rsp_remainder_q <= '0;
      rsp_tag_q       <= '0;
      rsp_dbz_q       <= 1'b0;
      rsp_timeout_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      op_dividend_q   <= op_dividend_d;
      op_divisor_q    <= op_divisor_d;
      to_cnt_q        <= to_cnt_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_quotient_q  <= rsp_quotient_d;
      rsp_remainder_q <= rsp_remainder_d;
      rsp_tag_q       <= rsp_tag_d;
      rsp_dbz_q       <= rsp_dbz_d;
      rsp_timeout_q   <= rsp_timeout_d;
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_quotient  = rsp_quotient_q;
  assign rsp_remainder = rsp_remainder_q;
  assign rsp_tag       = rsp_tag_q;
  assign rsp_dbz       = rsp_dbz_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign div_start     = (state_q == S_ISSUE);
  assign div_dividend  = op_dividend_q;
  assign div_divisor   = op_divisor_q;
  assign busy          = (state_q != S_IDLE);
  assign fifo_count    = count_q;

endmodule

// File: tb/tb_div_request_sequencer.sv
// -----------------------------------------------------------------------------
// tb_div_request_sequencer
//
// Directed bench for div_request_sequencer. A small behavioural divider
// answers each start pulse after DIV_LAT cycles (or never, for one chosen
// start). Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_div_request_sequencer;

  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 32;
  localparam int DIV_LAT = 9;

  logic             clk;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [7:0]       req_dividend;
  logic [7:0]       req_divisor;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_quotient;
  logic [7:0]       rsp_remainder;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_dbz;
  logic             rsp_timeout;
  logic             div_start;
  logic [7:0]       div_dividend;
  logic [7:0]       div_divisor;
  logic [7:0]       div_quotient  = 8'd0;
  logic [7:0]       div_remainder = 8'd0;
  logic             div_ready     = 1'b1;
  logic             busy;
  logic [2:0]       fifo_count;

  int vectors       = 0;
  int miscompares   = 0;
  int cyc           = 0;
  int start_cnt     = 0;
  int last_start_cyc = 0;
  int stuck_start_no = -1;
  int s0;

  logic [7:0] burst_dd [5] = '{8'd200, 8'd7, 8'd0, 8'd255, 8'd13};
  logic [7:0] burst_ds [5] = '{8'd9,   8'd7, 8'd5, 8'd1,   8'd4};
  logic [7:0] burst_q  [5] = '{8'd22,  8'd1, 8'd0, 8'd255, 8'd3};
  logic [7:0] burst_r  [5] = '{8'd2,   8'd0, 8'd0, 8'd0,   8'd1};

  div_request_sequencer #(
    .DEPTH   (DEPTH),
    .TAG_W   (TAG_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .req_tag       (req_tag),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_quotient  (rsp_quotient),
    .rsp_remainder (rsp_remainder),
    .rsp_tag       (rsp_tag),
    .rsp_dbz       (rsp_dbz),
    .rsp_timeout   (rsp_timeout),
    .div_start     (div_start),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .div_ready     (div_ready),
    .busy          (busy),
    .fifo_count    (fifo_count)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter, advanced on the active edge so falling-edge readers agree
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural divider: drops ready on start, raises it with the result
  // DIV_LAT falling edges later, unless this start is the one chosen to hang.
  int         lat = 0;
  logic       cur_stuck = 1'b0;
  logic [7:0] pend_q = 8'd0;
  logic [7:0] pend_r = 8'd0;
  always @(negedge clk) begin
    if (div_start) begin
      start_cnt      = start_cnt + 1;
      last_start_cyc = cyc;
      cur_stuck      = (start_cnt == stuck_start_no);
      div_ready      = 1'b0;
      lat            = DIV_LAT;
      pend_q         = div_dividend / div_divisor;
      pend_r         = div_dividend % div_divisor;
    end else if (!div_ready && !cur_stuck && lat > 0) begin
      lat = lat - 1;
      if (lat == 0) begin
        div_quotient  = pend_q;
        div_remainder = pend_r;
        div_ready     = 1'b1;
      end
    end
  end

  // Global time limit so a hung design still ends the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", name, observed, expected);
    end
  endtask

  // Present one request; it is pushed on the rising edge in between.
  task automatic applyStimulus(input logic [7:0] dd, input logic [7:0] ds,
                               input logic [TAG_W-1:0] tag);
    int n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("req_ready_before_push", {31'd0, req_ready}, 32'd1);
    req_valid    = 1'b1;
    req_dividend = dd;
    req_divisor  = ds;
    req_tag      = tag;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic waitRsp(input int bound);
    int n = 0;
    while (!rsp_valid && n < bound) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rsp_arrival", {31'd0, rsp_valid}, 32'd1);
  endtask

  // Wait for a response, check every field, then accept it.
  task automatic popRsp(input logic [7:0] q, input logic [7:0] r,
                        input logic [TAG_W-1:0] tag, input logic dbz,
                        input logic to);
    waitRsp(200);
    checkOutput("rsp_quotient",  {24'd0, rsp_quotient},  {24'd0, q});
    checkOutput("rsp_remainder", {24'd0, rsp_remainder}, {24'd0, r});
    checkOutput("rsp_tag",       {28'd0, rsp_tag},       {28'd0, tag});
    checkOutput("rsp_dbz",       {31'd0, rsp_dbz},       {31'd0, dbz});
    checkOutput("rsp_timeout",   {31'd0, rsp_timeout},   {31'd0, to});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("rsp_cleared", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_dividend = 8'd0;
    req_divisor  = 8'd0;
    req_tag      = '0;
    rsp_ready    = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    checkOutput("rst_req_ready",  {31'd0, req_ready}, 32'd1);
    checkOutput("rst_busy",       {31'd0, busy}, 32'd0);
    checkOutput("rst_fifo_count", {29'd0, fifo_count}, 32'd0);
    checkOutput("rst_rsp_valid",  {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst_div_start",  {31'd0, div_start}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single request 100/7 tag 3
    s0 = start_cnt;
    applyStimulus(8'd100, 8'd7, 4'd3);
    popRsp(8'd14, 8'd2, 4'd3, 1'b0, 1'b0);
    checkOutput("single_starts", start_cnt - s0, 32'd1);

    // Divide by zero: answered the cycle after the pop, divider untouched
    s0 = start_cnt;
    applyStimulus(8'd55, 8'd0, 4'd1);
    checkOutput("dbz_valid_pop_cycle", {31'd0, rsp_valid}, 32'd0);
    checkOutput("dbz_busy_pop_cycle",  {31'd0, busy}, 32'd0);
    @(negedge clk);
    checkOutput("dbz_valid_next", {31'd0, rsp_valid}, 32'd1);
    checkOutput("dbz_busy_next",  {31'd0, busy}, 32'd1);
    popRsp(8'hFF, 8'd55, 4'd1, 1'b1, 1'b0);
    checkOutput("dbz_starts", start_cnt - s0, 32'd0);

    // Burst of DEPTH+1 requests fills the FIFO
    for (int i = 0; i < 5; i++)
      applyStimulus(burst_dd[i], burst_ds[i], 4'(i));
    checkOutput("burst_full_count", {29'd0, fifo_count}, 32'd4);
    checkOutput("burst_full_ready", {31'd0, req_ready}, 32'd0);
    req_valid    = 1'b1;
    req_dividend = 8'd99;
    req_divisor  = 8'd3;
    req_tag      = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("burst_no_push_full", {29'd0, fifo_count}, 32'd4);
    for (int i = 0; i < 5; i++)
      popRsp(burst_q[i], burst_r[i], 4'(i), 1'b0, 1'b0);

    // Back-pressure with three requests queued
    applyStimulus(8'd50, 8'd6, 4'd5);
    applyStimulus(8'd9,  8'd2, 4'd6);
    applyStimulus(8'd81, 8'd9, 4'd7);
    waitRsp(200);
    s0 = start_cnt;
    for (int i = 0; i < 20; i++) begin
      checkOutput("bp_valid",     {31'd0, rsp_valid}, 32'd1);
      checkOutput("bp_quotient",  {24'd0, rsp_quotient}, 32'd8);
      checkOutput("bp_remainder", {24'd0, rsp_remainder}, 32'd2);
      checkOutput("bp_tag",       {28'd0, rsp_tag}, 32'd5);
      checkOutput("bp_fifo_count", {29'd0, fifo_count}, 32'd2);
      @(negedge clk);
    end
    checkOutput("bp_no_start", start_cnt - s0, 32'd0);
    popRsp(8'd8, 8'd2, 4'd5, 1'b0, 1'b0);
    popRsp(8'd4, 8'd1, 4'd6, 1'b0, 1'b0);
    popRsp(8'd9, 8'd0, 4'd7, 1'b0, 1'b0);

    // Stuck divider: timeout, then the next request still runs
    stuck_start_no = start_cnt + 1;
    applyStimulus(8'd10, 8'd3, 4'd8);
    applyStimulus(8'd20, 8'd3, 4'd9);
    waitRsp(200);
    checkOutput("to_latency", cyc - last_start_cyc, 32'(TIMEOUT + 2));
    popRsp(8'd0, 8'd0, 4'd8, 1'b0, 1'b1);
    popRsp(8'd6, 8'd2, 4'd9, 1'b0, 1'b0);

    // Reset in WAIT_DONE with two entries queued
    applyStimulus(8'd30, 8'd4, 4'd10);
    applyStimulus(8'd40, 8'd5, 4'd11);
    applyStimulus(8'd50, 8'd6, 4'd12);
    repeat (2) @(negedge clk);
    checkOutput("pre_rst_busy",  {31'd0, busy}, 32'd1);
    checkOutput("pre_rst_count", {29'd0, fifo_count}, 32'd2);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_busy",      {31'd0, busy}, 32'd0);
    checkOutput("mid_rst_count",     {29'd0, fifo_count}, 32'd0);
    checkOutput("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("mid_rst_div_start", {31'd0, div_start}, 32'd0);
    checkOutput("mid_rst_div_dd",    {24'd0, div_dividend}, 32'd0);
    reset = 1'b0;
    s0 = start_cnt;
    repeat (15) @(negedge clk);
    checkOutput("late_ready_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("late_ready_busy",      {31'd0, busy}, 32'd0);
    checkOutput("late_ready_starts",    start_cnt - s0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
